// File: rtl/store_commit_buffer_if.sv
// store_commit_buffer_if
// Groups the store-side, commit/kill, load-forwarding and data-memory write
// signals of the store commit buffer.
//   master : the pipeline side; drives stores, commit, kill and the load address
//   slave  : the buffer itself; drives ready, forwarding result, memory write, full/empty
interface store_commit_buffer_if #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
);
   logic                st_valid_i;
   logic [ADDR_LEN-1:0] st_addr_i;
   logic [DATA_LEN-1:0] st_data_i;
   logic                st_ready_o;
   logic                commit_i;
   logic                kill_i;
   logic [ADDR_LEN-1:0] ld_addr_i;
   logic                ld_hit_o;
   logic [DATA_LEN-1:0] ld_data_o;
   logic                dmem_we_o;
   logic [ADDR_LEN-1:0] dmem_waddr_o;
   logic [DATA_LEN-1:0] dmem_wdata_o;
   logic                full_o;
   logic                empty_o;

   modport master (
      output st_valid_i, st_addr_i, st_data_i, commit_i, kill_i, ld_addr_i,
      input  st_ready_o, ld_hit_o, ld_data_o, dmem_we_o, dmem_waddr_o,
             dmem_wdata_o, full_o, empty_o
   );

   modport slave (
      input  st_valid_i, st_addr_i, st_data_i, commit_i, kill_i, ld_addr_i,
      output st_ready_o, ld_hit_o, ld_data_o, dmem_we_o, dmem_waddr_o,
             dmem_wdata_o, full_o, empty_o
   );
endinterface

// File: rtl/store_commit_buffer.sv
// store_commit_buffer
// In-order buffer of executed stores. Stores wait speculatively until commit
// retires them, then drain one per cycle to data memory; kill discards every
// store that has not yet been committed.
// Ports:
//   clk_i   : clock
//   reset_i : asynchronous, active-high reset
//   bus     : store_commit_buffer_if.slave (store in, commit/kill, load lookup,
//             data-memory write, full/empty)
// Optional feature: define STORE_FWD_EN to forward the youngest buffered store
// matching ld_addr_i; otherwise ld_hit_o/ld_data_o are tied to zero.
module store_commit_buffer #(
   parameter int ENT_NUM  = 4,
   parameter int ENT_SEL  = 2,
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   store_commit_buffer_if.slave        bus
);
   localparam int PW = ENT_SEL + 1;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0]       head;
   logic [PW-1:0]       cptr;
   logic [PW-1:0]       tail;
   logic [PW-1:0]       count;
   logic [PW-1:0]       cptr_nxt;
   logic [ADDR_LEN-1:0] addr_q [ENT_NUM];
   logic [DATA_LEN-1:0] data_q [ENT_NUM];
   logic                full;
   logic                push;
   logic                commit_fire;
   logic                drain;

   assign count       = tail - head;
   assign full        = (count == PW'(ENT_NUM));
   assign push        = bus.st_valid_i && !full && !bus.kill_i;
   assign commit_fire = bus.commit_i && (cptr != tail);
   assign drain       = (head != cptr);
   assign cptr_nxt    = commit_fire ? cptr + PW'(1) : cptr;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         head <= '0;
         cptr <= '0;
         tail <= '0;
      end else begin
         cptr <= cptr_nxt;
         // Kill rolls tail back to the commit point, so committed stores survive.
         if (bus.kill_i)
            tail <= cptr_nxt;
         else if (push)
            tail <= tail + PW'(1);
         if (drain)
            head <= head + PW'(1);
      end
   end

   // Entry contents need no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[tail[ENT_SEL-1:0]] <= bus.st_addr_i;
         data_q[tail[ENT_SEL-1:0]] <= bus.st_data_i;
      end
   end

   assign bus.st_ready_o   = !full;
   assign bus.full_o       = full;
   assign bus.empty_o      = (count == '0);
   assign bus.dmem_we_o    = drain;
   assign bus.dmem_waddr_o = drain ? addr_q[head[ENT_SEL-1:0]] : '0;
   assign bus.dmem_wdata_o = drain ? data_q[head[ENT_SEL-1:0]] : '0;

`ifdef STORE_FWD_EN
   logic [ENT_SEL-1:0]  fwd_idx;
   logic                fwd_hit;
   logic [DATA_LEN-1:0] fwd_data;

   // Walk oldest to youngest; a later match overwrites, leaving the youngest.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
         fwd_idx = head[ENT_SEL-1:0] + ENT_SEL'(i);
         if ((PW'(i) < count) && (addr_q[fwd_idx] == bus.ld_addr_i)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end

   assign bus.ld_hit_o  = fwd_hit;
   assign bus.ld_data_o = fwd_data;
`else
   assign bus.ld_hit_o  = 1'b0;
   assign bus.ld_data_o = '0;
`endif
endmodule
